// File: rtl/mtds_pkg.sv
// ============================================================================
//  Module   : mtds_pkg
//  Purpose  : Shared types, default constants and the output limiter for
//             multitap_delay_scale.
//  Contents : mtds_state_t  - control FSM state encoding
//             C_*           - default parameter values
//             mtds_sat_trunc- clamp (or pass-through for wrap) of a result
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package mtds_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } mtds_state_t;

    localparam int C_WIDTH   = 16;
    localparam int C_DEPTH   = 256;
    localparam int C_TAPS    = 4;
    localparam int C_SCALE_W = 5;

    // With i_sat set the value is clamped to the signed range of i_width bits.
    // Without it the value is returned untouched and the caller keeps only the
    // low i_width bits, which gives two's-complement wrap.
    function automatic logic signed [63:0] mtds_sat_trunc(
        input logic signed [63:0] i_val,
        input int                 i_width,
        input logic               i_sat
    );
        logic signed [63:0] w_max;
        logic signed [63:0] w_min;
        w_max = (64'sd1 <<< (i_width - 1)) - 64'sd1;
        w_min = -w_max - 64'sd1;
        if (!i_sat)
            return i_val;
        if (i_val > w_max)
            return w_max;
        if (i_val < w_min)
            return w_min;
        return i_val;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mtds_sample_ram.sv
// ============================================================================
//  Module   : mtds_sample_ram
//  Purpose  : Sample history buffer, one write port and one registered read
//             port, written so it maps onto a block RAM.
//  Ports    : clk        - clock
//             i_wr_en    - write strobe
//             i_wr_addr  - write address
//             i_wr_data  - write data
//             i_rd_addr  - read address (data appears one clock later)
//             o_rd_data  - registered read data
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mtds_sample_ram
    import mtds_pkg::*;
#(
    parameter int WIDTH = C_WIDTH,
    parameter int DEPTH = C_DEPTH
) (
    input  logic                       clk,
    input  logic                       i_wr_en,
    input  logic [$clog2(DEPTH)-1:0]   i_wr_addr,
    input  logic signed [WIDTH-1:0]    i_wr_data,
    input  logic [$clog2(DEPTH)-1:0]   i_rd_addr,
    output logic signed [WIDTH-1:0]    o_rd_data
);

    // No reset: contents survive reset and stale entries are masked upstream.
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en)
            r_mem[i_wr_addr] <= i_wr_data;
        o_rd_data <= r_mem[i_rd_addr];
    end

endmodule

`default_nettype wire

// File: rtl/multitap_delay_scale.sv
// ============================================================================
//  Module   : multitap_delay_scale
//  Purpose  : Multi-tap delay line with per-tap fixed-point gain. Each accepted
//             sample produces y = (sum of enabled x[n-d_k]*s_k) >>> (SCALE_W-1).
//  Ports    : clk_in      - clock
//             reset_in    - synchronous active-high reset
//             ready_in    - sample strobe (taken only while busy_out is low)
//             signal_in   - input sample, signed
//             delay_in    - per-tap delay in samples
//             scale_in    - per-tap unsigned gain, 1.0 = 1 << (SCALE_W-1)
//             tap_en_in   - per-tap enable
//             signal_out  - result, held between done_out pulses
//             done_out    - one-cycle result strobe
//             busy_out    - computation in progress
//             overrun_out - sticky: a strobe arrived while busy
//  Config   : define MTDS_SATURATE_EN to clamp the result instead of wrapping.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module multitap_delay_scale
    import mtds_pkg::*;
#(
    parameter int WIDTH   = C_WIDTH,
    parameter int DEPTH   = C_DEPTH,
    parameter int TAPS    = C_TAPS,
    parameter int SCALE_W = C_SCALE_W
) (
    input  logic                                  clk_in,
    input  logic                                  reset_in,
    input  logic                                  ready_in,
    input  logic signed [WIDTH-1:0]               signal_in,
    input  logic [TAPS-1:0][$clog2(DEPTH)-1:0]    delay_in,
    input  logic [TAPS-1:0][SCALE_W-1:0]          scale_in,
    input  logic [TAPS-1:0]                       tap_en_in,
    output logic signed [WIDTH-1:0]               signal_out,
    output logic                                  done_out,
    output logic                                  busy_out,
    output logic                                  overrun_out
);

    localparam int C_AW     = $clog2(DEPTH);
    localparam int C_FRAC   = SCALE_W - 1;
    localparam int C_PROD_W = WIDTH + SCALE_W + 1;
    localparam int C_ACC_W  = C_PROD_W + $clog2(TAPS);
    localparam int C_CW     = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam logic [C_AW:0]   C_FILL_MAX = (C_AW + 1)'(DEPTH);
    localparam logic [C_CW-1:0] C_LAST_TAP = C_CW'(TAPS - 1);
`ifdef MTDS_SATURATE_EN
    localparam logic C_SAT_EN = 1'b1;
`else
    localparam logic C_SAT_EN = 1'b0;
`endif

    // Control
    mtds_state_t              r_state;
    mtds_state_t              w_state_nxt;
    logic [C_CW-1:0]          r_cnt;
    logic                     r_drain;
    logic                     r_busy;
    logic                     r_done;
    logic                     r_overrun;
    logic                     w_accept;
    logic                     w_issue;

    // Buffer bookkeeping and captured configuration
    logic [C_AW-1:0]              r_wr_ptr;
    logic [C_AW:0]                r_fill;
    logic [C_AW-1:0]              r_base;
    logic [TAPS-1:0][C_AW-1:0]    r_delay;
    logic [TAPS-1:0][SCALE_W-1:0] r_scale;
    logic [TAPS-1:0]              r_en;

    // Datapath pipeline: read -> multiply -> accumulate -> output
    logic [C_AW-1:0]              w_tap_delay;
    logic                         w_tap_live;
    logic [C_AW-1:0]              w_rd_addr;
    logic signed [WIDTH-1:0]      w_rd_data;
    logic [SCALE_W-1:0]           r_rd_scale;
    logic                         r_rd_vld;
    logic                         r_rd_last;
    logic signed [C_PROD_W-1:0]   r_prod;
    logic                         r_prod_vld;
    logic                         r_prod_last;
    logic signed [C_ACC_W-1:0]    r_acc;
    logic                         r_acc_last;
    logic signed [C_ACC_W-1:0]    w_shifted;
    logic signed [63:0]           w_limited;
    logic signed [WIDTH-1:0]      r_signal;

    assign w_accept = ready_in && !r_busy;

    // The tap whose address is issued this cycle; it contributes only when
    // enabled and when the requested history has actually been written.
    assign w_tap_delay = r_delay[r_cnt];
    assign w_tap_live  = r_en[r_cnt] && ({1'b0, w_tap_delay} < r_fill);
    assign w_rd_addr   = r_base - w_tap_delay;

    mtds_sample_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk       (clk_in),
        .i_wr_en   (w_accept),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (signal_in),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_data)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept)
                    w_state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                w_issue = 1'b1;
                if (r_cnt == C_LAST_TAP)
                    w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (r_drain)
                    w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_drain     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_overrun   <= 1'b0;
            r_wr_ptr    <= '0;
            r_fill      <= '0;
            r_rd_vld    <= 1'b0;
            r_rd_last   <= 1'b0;
            r_prod_vld  <= 1'b0;
            r_prod_last <= 1'b0;
            r_acc_last  <= 1'b0;
            r_signal    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_drain <= (r_state == ST_DRAIN) && !r_drain;
            r_cnt   <= w_issue ? r_cnt + 1'b1 : '0;

            if (w_accept) begin
                r_busy   <= 1'b1;
                r_base   <= r_wr_ptr;
                r_wr_ptr <= r_wr_ptr + 1'b1;
                r_delay  <= delay_in;
                r_scale  <= scale_in;
                r_en     <= tap_en_in;
                if (r_fill != C_FILL_MAX)
                    r_fill <= r_fill + 1'b1;
            end else if (r_acc_last) begin
                r_busy <= 1'b0;
            end

            if (ready_in && r_busy)
                r_overrun <= 1'b1;

            // A masked tap is given zero gain so it still flows through the
            // pipeline and keeps the latency fixed.
            r_rd_vld   <= w_issue;
            r_rd_last  <= w_issue && (r_cnt == C_LAST_TAP);
            r_rd_scale <= (w_issue && w_tap_live) ? r_scale[r_cnt] : '0;

            r_prod      <= C_PROD_W'(w_rd_data) * C_PROD_W'($signed({1'b0, r_rd_scale}));
            r_prod_vld  <= r_rd_vld;
            r_prod_last <= r_rd_last;

            if (w_accept)
                r_acc <= '0;
            else if (r_prod_vld)
                r_acc <= r_acc + C_ACC_W'(r_prod);
            r_acc_last <= r_prod_vld && r_prod_last;

            r_done <= r_acc_last;
            if (r_acc_last)
                r_signal <= w_limited[WIDTH-1:0];
        end
    end

    // Arithmetic shift gives floor rounding for negative sums.
    assign w_shifted = r_acc >>> C_FRAC;
    assign w_limited = mtds_sat_trunc(64'(w_shifted), WIDTH, C_SAT_EN);

    assign signal_out  = r_signal;
    assign done_out    = r_done;
    assign busy_out    = r_busy;
    assign overrun_out = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_multitap_delay_scale.sv
// ============================================================================
//  Module   : tb_multitap_delay_scale
//  Purpose  : Self-checking bench for multitap_delay_scale (16/256/4/5).
//             Expected results are queued at each accept and compared when
//             done_out fires, together with the accept-to-done latency.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_multitap_delay_scale;

    logic                    clk_in;
    logic                    reset_in;
    logic                    ready_in;
    logic signed [15:0]      signal_in;
    logic [3:0][7:0]         delay_in;
    logic [3:0][4:0]         scale_in;
    logic [3:0]              tap_en_in;
    logic signed [15:0]      signal_out;
    logic                    done_out;
    logic                    busy_out;
    logic                    overrun_out;

    multitap_delay_scale dut (
        .clk_in      (clk_in),
        .reset_in    (reset_in),
        .ready_in    (ready_in),
        .signal_in   (signal_in),
        .delay_in    (delay_in),
        .scale_in    (scale_in),
        .tap_en_in   (tap_en_in),
        .signal_out  (signal_out),
        .done_out    (done_out),
        .busy_out    (busy_out),
        .overrun_out (overrun_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    longint cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    typedef struct {
        longint val;
        longint cyc;
    } exp_t;

    exp_t   sb[$];
    exp_t   e_mon;
    int     n_total = 0;
    int     n_bad   = 0;

    // Reference model of the history buffer
    longint m_mem [256];
    int     m_wptr = 0;
    int     m_fill = 0;

`ifdef MTDS_SATURATE_EN
    localparam longint C_FULL_SCALE_EXP = 32767;
`else
    localparam longint C_FULL_SCALE_EXP = -8200;
`endif

    task automatic chk(input string tag, input longint got, input longint exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint model_out(input int base, input logic [3:0][7:0] d,
                                         input logic [3:0][4:0] s, input logic [3:0] en);
        longint acc;
        longint v;
        acc = 0;
        for (int k = 0; k < 4; k++)
            if (en[k] && int'(d[k]) < m_fill)
                acc += m_mem[(base - int'(d[k]) + 256) % 256] * longint'(s[k]);
        v = acc >>> 4;
`ifdef MTDS_SATURATE_EN
        if (v > 32767) v = 32767;
        else if (v < -32768) v = -32768;
`else
        v = longint'(shortint'(v));
`endif
        return v;
    endfunction

    // Offer one sample as soon as the DUT is free; queue the expected result.
    task automatic send(input longint x, input logic [3:0][7:0] d, input logic [3:0][4:0] s,
                        input logic [3:0] en, input bit use_exp, input longint exp_v);
        int     n;
        int     base;
        longint v;
        n = 0;
        @(negedge clk_in);
        while (busy_out && n < 60) begin
            @(negedge clk_in);
            n++;
        end
        if (busy_out) chk("busy_timeout", 1, 0);
        signal_in = 16'(x);
        delay_in  = d;
        scale_in  = s;
        tap_en_in = en;
        ready_in  = 1'b1;
        @(posedge clk_in);
        #1;
        ready_in = 1'b0;
        base = m_wptr;
        m_mem[base] = longint'(signal_in);
        m_wptr = (m_wptr + 1) % 256;
        if (m_fill < 256) m_fill++;
        v = model_out(base, d, s, en);
        if (use_exp) v = exp_v;
        sb.push_back('{val: v, cyc: cyc});
        // Configuration changes after the accept must not matter.
        delay_in  = 32'($urandom);
        scale_in  = 20'($urandom);
        tap_en_in = 4'($urandom);
        signal_in = 16'($urandom);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk_in);
            n++;
        end
        if (sb.size() != 0) chk("drain_timeout", longint'(sb.size()), 0);
    endtask

    task automatic do_reset();
        reset_in = 1'b1;
        @(posedge clk_in);
        #1;
        reset_in = 1'b0;
        sb.delete();
        m_wptr = 0;
        m_fill = 0;
    endtask

    always @(negedge clk_in) begin
        if (!reset_in && done_out) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e_mon = sb.pop_front();
                chk("signal_out", longint'(signal_out), e_mon.val);
                chk("latency", cyc - e_mon.cyc, 7);
            end
        end
    end

    initial begin
        logic [3:0][7:0] d;
        logic [3:0][4:0] s;

        reset_in  = 1'b1;
        ready_in  = 1'b0;
        signal_in = '0;
        delay_in  = '0;
        scale_in  = '0;
        tap_en_in = '0;
        repeat (3) @(posedge clk_in);
        #1;
        reset_in = 1'b0;
        chk("rst_signal_out", longint'(signal_out), 0);
        chk("rst_done", longint'(done_out), 0);
        chk("rst_busy", longint'(busy_out), 0);
        chk("rst_overrun", longint'(overrun_out), 0);

        // Single tap, delay 0, unity gain
        d = '0; s = '0; s[0] = 5'd16;
        send(1000, d, s, 4'b0001, 1, 1000);
        chk("busy_after_accept", longint'(busy_out), 1);
        wait_idle();

        // Impulse through a 25-sample delay
        do_reset();
        d = '0; d[0] = 8'd25; s = '0; s[0] = 5'd16;
        for (int i = 0; i < 30; i++)
            send((i == 0) ? 1000 : 0, d, s, 4'b0001, 1, (i == 25) ? 1000 : 0);
        wait_idle();

        // Two taps; the delayed one is masked until history exists
        do_reset();
        d = '0; d[1] = 8'd1; s = '0; s[0] = 5'd16; s[1] = 5'd8;
        for (int i = 0; i < 4; i++)
            send(1000, d, s, 4'b0011, 1, (i == 0) ? 1000 : 1500);

        // Full-scale input on all taps at maximum gain
        d = '0; s = {5'd31, 5'd31, 5'd31, 5'd31};
        send(32767, d, s, 4'b1111, 1, C_FULL_SCALE_EXP);
        send(-32768, d, s, 4'b1111, 0, 0);

        // All taps disabled
        send(1234, d, s, 4'b0000, 1, 0);

        // Random traffic, back to back, checked against the model
        for (int i = 0; i < 24; i++) begin
            for (int k = 0; k < 4; k++) begin
                d[k] = 8'($urandom_range(0, 40));
                s[k] = 5'($urandom_range(0, 31));
            end
            send(longint'($signed(16'($urandom))), d, s, 4'($urandom), 0, 0);
        end
        wait_idle();
        chk("no_overrun_yet", longint'(overrun_out), 0);

        // Strobe two edges after an accept must be dropped
        d = '0; s = '0; s[0] = 5'd16;
        send(500, d, s, 4'b0001, 1, 500);
        @(posedge clk_in);
        #1;
        signal_in = 16'sd777;
        ready_in  = 1'b1;
        @(posedge clk_in);
        #1;
        ready_in = 1'b0;
        chk("overrun_set", longint'(overrun_out), 1);
        d[0] = 8'd1;
        send(0, d, s, 4'b0001, 1, 500);
        wait_idle();
        chk("overrun_sticky", longint'(overrun_out), 1);

        // Reset in the middle of ISSUE aborts without a result
        d = '0; s = '0; s[0] = 5'd16;
        send(3000, d, s, 4'b0001, 0, 0);
        @(posedge clk_in);
        #1;
        reset_in = 1'b1;
        @(posedge clk_in);
        #1;
        reset_in = 1'b0;
        sb.delete();
        m_wptr = 0;
        m_fill = 0;
        chk("abort_busy", longint'(busy_out), 0);
        chk("abort_done", longint'(done_out), 0);
        chk("abort_signal_out", longint'(signal_out), 0);
        chk("abort_overrun", longint'(overrun_out), 0);
        repeat (12) @(negedge clk_in);
        d[0] = 8'd5;
        send(2000, d, s, 4'b0001, 1, 0);
        wait_idle();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/multitap_delay_scale.md
MULTITAP_DELAY_SCALE -- requirements
Module: multitap_delay_scale

Interface
REQ-001 SHALL have parameter WIDTH, default 16, sample width (signed two's complement).
REQ-002 SHALL have parameter DEPTH, default 256, history length in samples; power of two; AW = clog2(DEPTH).
REQ-003 SHALL have parameter TAPS, default 4, number of delay/scale taps.
REQ-004 SHALL have parameter SCALE_W, default 5, unsigned scale width; FRAC = SCALE_W-1 fraction bits, so 5'b10000 = 1.0.
REQ-005 SHALL have ports, clock and reset first: clk_in in 1 clock; reset_in in 1 reset, synchronous, active-high.
REQ-006 SHALL have ports: ready_in in 1, sample strobe; signal_in in WIDTH signed, input sample.
REQ-007 SHALL have ports: delay_in in TAPS x AW, per-tap delay; scale_in in TAPS x SCALE_W, per-tap gain; tap_en_in in TAPS, per-tap enable.
REQ-008 SHALL have ports: signal_out out WIDTH signed; done_out out 1, result pulse; busy_out out 1; overrun_out out 1, sticky.

Function
REQ-009 SHALL accept a sample on a clk_in edge with ready_in=1 and busy_out=0, writing signal_in to a circular buffer at wr_ptr, then incrementing wr_ptr mod DEPTH.
REQ-010 SHALL capture delay_in, scale_in and tap_en_in at the accepting edge; changes during processing SHALL have no effect.
REQ-011 SHALL compute y = sum over enabled k of x[n - delay_k] * scale_k, arithmetic right-shifted by FRAC (floor), where delay 0 selects the just-accepted sample.
REQ-012 SHALL treat a tap as contributing 0 when delay_k >= fill, where fill counts accepted samples since reset, saturating at DEPTH.
REQ-013 SHALL accumulate at width WIDTH+SCALE_W+1+clog2(TAPS) with no internal overflow.
REQ-014 SHALL use FSM states IDLE -> ISSUE (TAPS cycles, one buffer read per tap) -> DRAIN (2 cycles, read and multiply pipeline) -> IDLE.
REQ-015 SHALL update signal_out and pulse done_out for exactly one cycle on the (TAPS+3)-th edge after the accepting edge; signal_out SHALL hold until the next done_out.
REQ-016 SHALL drive busy_out=1 from the accepting edge until the edge that asserts done_out, at which busy_out returns to 0.
REQ-017 SHALL accept a ready_in coinciding with the done_out cycle, since busy_out is 0 there.
REQ-018 SHALL ignore ready_in while busy_out=1, leave buffer and wr_ptr unchanged, and set overrun_out.
REQ-019 SHALL output 0 when all taps are disabled, still pulsing done_out at the normal latency.

Reset
REQ-020 SHALL, on reset_in=1 at an edge, set signal_out=0, done_out=0, busy_out=0, overrun_out=0, wr_ptr=0, fill=0 and FSM=IDLE; this applies mid-operation, aborting the computation with no done_out.
REQ-021 SHALL NOT clear buffer contents on reset; the fill rule (REQ-012) masks stale data.

Configuration
REQ-022 SHALL, with MTDS_SATURATE_EN defined, clamp the shifted result to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
REQ-023 SHALL, without MTDS_SATURATE_EN, output the low WIDTH bits of the shifted result (wrap).

Structure
REQ-024 SHALL place the FSM state enum, default parameter constants and the saturate/truncate function in package mtds_pkg.
REQ-025 SHALL implement the history buffer as sub-module mtds_sample_ram: one write port, one read port, registered read, inferable as block RAM.

Verification (WIDTH=16, DEPTH=256, TAPS=4, SCALE_W=5)
REQ-026 SHALL cover: tap0 only, delay 0, scale 16, input 1000 -> signal_out 1000 with done_out 7 edges after accept.
REQ-027 SHALL cover: tap0 only, delay 25, scale 16, impulse 1000 at sample 0 then zeros -> outputs 0 for samples 0..24, 1000 at sample 25, 0 after.
REQ-028 SHALL cover: tap0 delay 0 scale 16 plus tap1 delay 1 scale 8, constant 1000 after reset -> first output 1000 (fill masks tap1), then 1500.
REQ-029 SHALL cover: all taps delay 0, scale 31, input 32767 -> 32767 with MTDS_SATURATE_EN, -8200 without.
REQ-030 SHALL cover: ready_in re-pulsed 2 edges after an accept -> ignored, overrun_out=1, exactly one done_out, wr_ptr advanced by 1.
REQ-031 SHALL cover: reset_in during ISSUE -> busy_out=0 next edge, no done_out; next accept with tap0 delay 5 -> output 0.
